router_sync: RTL and testbench
==============================

ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30: consecutive unread valid cycles before a port's soft reset fires; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port detect_addr  input  1  FSM strobe: capture destination address from data_in.
REQ-005 SHALL have port data_in  input  2  destination address (00/01/10 valid; 11 = no port).
REQ-006 SHALL have port write_enb_reg  input  1  FSM write request for the current packet byte.
REQ-007 SHALL have ports read_enb_0, read_enb_1, read_enb_2  input  1 each  downstream reads of FIFO 0/1/2.
REQ-008 SHALL have ports empty_0, empty_1, empty_2  input  1 each  FIFO 0/1/2 empty flags.
REQ-009 SHALL have ports full_0, full_1, full_2  input  1 each  FIFO 0/1/2 full flags.
REQ-010 SHALL have port write_enb  output  3  one-hot FIFO write enable, bit n = FIFO n.
REQ-011 SHALL have port fifo_full  output  1  full flag of the addressed FIFO, to FSM.
REQ-012 SHALL have ports vld_out_0, vld_out_1, vld_out_2  output  1 each  FIFO n holds data.
REQ-013 SHALL have ports soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  one-cycle flush pulse to FIFO n and FSM.

Function
REQ-014 SHALL hold a 2-bit addr_reg, loaded with data_in on a rising edge where detect_addr=1; otherwise held.
REQ-015 SHALL drive write_enb combinationally: one-hot of addr_reg when write_enb_reg=1, else 3'b000; addr_reg=11 gives 3'b000.
REQ-016 SHALL drive fifo_full combinationally as full_<addr_reg>; 0 when addr_reg=11.
REQ-017 SHALL use the registered addr_reg value when detect_addr and write_enb_reg are both 1 in the same cycle; no bypass of data_in.
REQ-018 SHALL drive vld_out_n = ~empty_n combinationally.
REQ-019 SHALL keep one independent 8-bit timeout counter cnt_n per port.
REQ-020 SHALL apply this counter rule per port each edge: if vld_out_n=1 and read_enb_n=0, then at cnt_n=TIMEOUT-1 set cnt_n to 0 and soft_reset_n to 1, else increment cnt_n and set soft_reset_n to 0.
REQ-021 SHALL, in all other cases (read_enb_n=1 or vld_out_n=0), set cnt_n to 0 and soft_reset_n to 0.
REQ-022 SHALL therefore register soft_reset_n high for exactly one cycle, immediately after the TIMEOUT-th consecutive unread valid edge.
REQ-023 SHALL fire again after another TIMEOUT unread valid edges if the FIFO stays non-empty after a flush.
REQ-024 SHALL treat a read_enb_n pulse on the edge that would reach TIMEOUT as a read: counter clears, no pulse.
REQ-025 SHALL keep the three ports fully independent; any combination of soft_reset outputs may pulse in the same cycle.

Reset
REQ-026 SHALL, on a rising edge with rst=1, set addr_reg=11, all cnt_n=0 and all soft_reset_n=0, overriding detect_addr and the counter rule.
REQ-027 SHALL output write_enb=000 and fifo_full=0 from the edge after reset until the next detect_addr.
REQ-028 SHALL, on reset mid-count, discard the count; counting restarts from 0 after rst deasserts.

Configuration
REQ-029 SHALL compile the timeout counters and soft-reset generation only when macro ROUTER_SYNC_SOFT_RESET_EN is defined.
REQ-030 SHALL, without ROUTER_SYNC_SOFT_RESET_EN, tie soft_reset_0..2 to 0, omit the cnt_n registers, and keep all other behaviour identical.

Verification
REQ-031 SHALL cover: rst=1 one edge -> write_enb=000, fifo_full=0, soft_reset_0..2=0.
REQ-032 SHALL cover: detect_addr=1 with data_in=01, next cycle write_enb_reg=1 -> write_enb=010; full_1=1 -> fifo_full=1; full_0=1 alone -> fifo_full=0.
REQ-033 SHALL cover: detect_addr=1 with data_in=11, then write_enb_reg=1 -> write_enb=000, fifo_full=0.
REQ-034 SHALL cover: empty_2=0 with read_enb_2=0 for 30 edges (TIMEOUT=30) -> soft_reset_2=1 exactly one cycle after edge 30, soft_reset_0/1 stay 0.
REQ-035 SHALL cover: empty_0=0, read_enb_0=1 at edge 29 -> no soft_reset_0 at edge 30; pulse only after 30 further unread edges.
REQ-036 SHALL cover: rst=1 at edge 15 of a count -> no pulse at edge 30; pulse at edge 30 counted from rst deassertion.

Source files
------------

// File: rtl/router_sync.sv
// Router synchroniser: latches the destination port, steers FIFO writes/full status,
// and (with ROUTER_SYNC_SOFT_RESET_EN defined) flushes FIFOs left unread for TIMEOUT cycles.
module router_sync #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_addr,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0] addr_q, addr_d;
  logic [2:0] vld;
  logic [2:0] rd;

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  always_comb begin
    addr_d = detect_addr ? data_in : addr_q;
  end

  // Decode uses the registered address only; a same-cycle detect_addr is not bypassed.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin write_enb = {2'b00, write_enb_reg};       fifo_full = full_0; end
      2'b01: begin write_enb = {1'b0, write_enb_reg, 1'b0};  fifo_full = full_1; end
      2'b10: begin write_enb = {write_enb_reg, 2'b00};       fifo_full = full_2; end
      default: begin write_enb = '0;                         fifo_full = 1'b0;   end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= 2'b11;
    else     addr_q <= addr_d;
  end

`ifdef ROUTER_SYNC_SOFT_RESET_EN
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];
  logic [2:0] soft_reset_q, soft_reset_d;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i]        = '0;
      soft_reset_d[i] = 1'b0;
      if (vld[i] && !rd[i]) begin
        if (cnt_q[i] == TIMEOUT_M1) soft_reset_d[i] = 1'b1;
        else                        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '{default: '0};
      soft_reset_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset_0 = soft_reset_q[0];
  assign soft_reset_1 = soft_reset_q[1];
  assign soft_reset_2 = soft_reset_q[2];
`else
  logic unused_rd;
  assign unused_rd = ^rd;

  assign soft_reset_0 = 1'b0;
  assign soft_reset_1 = 1'b0;
  assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: address decode, full steering, valid flags and
// per-port unread-timeout flush pulses, against a counting reference model.
module tb_router_sync;
  localparam int unsigned TIMEOUT = 30;
`ifdef ROUTER_SYNC_SOFT_RESET_EN
  localparam bit SR_EN = 1'b1;
`else
  localparam bit SR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, detect_addr, write_enb_reg;
  logic [1:0] data_in;
  logic [2:0] rd_v, empty_v, full_v;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [2:0] sr, vld;

  int tests = 0;
  int fails = 0;

  // Reference model: destination index (3 = none), consecutive unread-valid edge counts.
  int         m_addr;
  int         m_run [3];
  logic [2:0] exp_sr;

  assign sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign vld = {vld_out_2, vld_out_1, vld_out_0};

  always #5 clk = ~clk;

  router_sync #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .detect_addr(detect_addr), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(rd_v[0]), .read_enb_1(rd_v[1]), .read_enb_2(rd_v[2]),
    .empty_0(empty_v[0]), .empty_1(empty_v[1]), .empty_2(empty_v[2]),
    .full_0(full_v[0]), .full_1(full_v[1]), .full_2(full_v[2]),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  function automatic logic [2:0] exp_we();
    return (m_addr < 3 && write_enb_reg) ? (3'b001 << m_addr) : 3'b000;
  endfunction

  function automatic logic exp_ff();
    return (m_addr < 3) ? full_v[m_addr] : 1'b0;
  endfunction

  // Advance one rising edge and update the model from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_addr = 3;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      exp_sr = 3'b000;
    end else begin
      if (detect_addr) m_addr = int'(data_in);
      for (int i = 0; i < 3; i++) begin
        exp_sr[i] = 1'b0;
        if (!empty_v[i] && !rd_v[i]) begin
          m_run[i]++;
          if (m_run[i] == TIMEOUT) begin
            m_run[i]  = 0;
            exp_sr[i] = SR_EN;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; detect_addr = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    rd_v = 3'b000; empty_v = 3'b111; full_v = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; detect_addr = 1'b1; data_in = 2'b01;
    tick();
    rst = 1'b0; detect_addr = 1'b0; write_enb_reg = 1'b1; full_v = 3'b111;
    #1;
    tests++; if (write_enb !== 3'b000) begin fails++; $display("FAIL reset_we got=%b exp=000", write_enb); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_ff got=%b exp=0", fifo_full); end
    tests++; if (sr !== 3'b000) begin fails++; $display("FAIL reset_sr got=%b exp=000", sr); end
    tests++; if (vld !== 3'b000) begin fails++; $display("FAIL reset_vld got=%b exp=000", vld); end
  endtask

  task automatic test_decode();
    idle_inputs();
    detect_addr = 1'b1; data_in = 2'b01;
    tick();
    detect_addr = 1'b0; write_enb_reg = 1'b1; #1;
    tests++; if (write_enb !== 3'b010) begin fails++; $display("FAIL dec01_we got=%b exp=010", write_enb); end
    full_v = 3'b010; #1;
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL dec01_full1 got=%b exp=1", fifo_full); end
    full_v = 3'b001; #1;
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL dec01_full0 got=%b exp=0", fifo_full); end
    // Same-cycle detect/write must still use the previously registered address.
    detect_addr = 1'b1; data_in = 2'b10; #1;
    tests++; if (write_enb !== 3'b010) begin fails++; $display("FAIL nobypass_we got=%b exp=010", write_enb); end
    tick();
    data_in = 2'b11; #1;
    tests++; if (write_enb !== 3'b100) begin fails++; $display("FAIL dec10_we got=%b exp=100", write_enb); end
    tick();
    detect_addr = 1'b0; full_v = 3'b111; #1;
    tests++; if (write_enb !== 3'b000) begin fails++; $display("FAIL dec11_we got=%b exp=000", write_enb); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL dec11_ff got=%b exp=0", fifo_full); end
    for (int n = 0; n < 200; n++) begin
      detect_addr = 1'($urandom_range(0, 2) == 0); data_in = 2'($urandom);
      write_enb_reg = 1'($urandom); full_v = 3'($urandom); empty_v = 3'($urandom);
      #1;
      tests++; if (write_enb !== exp_we()) begin fails++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, write_enb, exp_we()); end
      tests++; if (fifo_full !== exp_ff()) begin fails++; $display("FAIL rnd_ff n=%0d got=%b exp=%b", n, fifo_full, exp_ff()); end
      tests++; if (vld !== ~empty_v) begin fails++; $display("FAIL rnd_vld n=%0d got=%b exp=%b", n, vld, ~empty_v); end
      tick();
    end
  endtask

  task automatic test_timeout_port2();
    int pulses;
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    empty_v = 3'b011; pulses = 0;
    for (int e = 1; e <= TIMEOUT + 2; e++) begin
      tick();
      if (soft_reset_2) pulses++;
      tests++; if (sr !== exp_sr) begin fails++; $display("FAIL to2 edge=%0d got=%b exp=%b", e, sr, exp_sr); end
      if (e == TIMEOUT) begin
        tests++; if (sr !== {SR_EN, 2'b00}) begin fails++; $display("FAIL to2_fire edge=%0d got=%b exp=%b", e, sr, {SR_EN, 2'b00}); end
      end
    end
    tests++; if (pulses !== int'(SR_EN)) begin fails++; $display("FAIL to2_pulses got=%0d exp=%0d", pulses, int'(SR_EN)); end
  endtask

  task automatic test_read_late();
    int fire_edge;
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    empty_v = 3'b110; fire_edge = -1;
    for (int e = 1; e <= 2 * TIMEOUT + 3; e++) begin
      rd_v[0] = (e == TIMEOUT - 1);
      tick();
      if (soft_reset_0 && fire_edge < 0) fire_edge = e;
      tests++; if (sr !== exp_sr) begin fails++; $display("FAIL rdlate edge=%0d got=%b exp=%b", e, sr, exp_sr); end
    end
    tests++; if (fire_edge !== (SR_EN ? 2 * TIMEOUT - 1 : -1)) begin
      fails++; $display("FAIL rdlate_fire got=%0d exp=%0d", fire_edge, SR_EN ? 2 * TIMEOUT - 1 : -1); end
  endtask

  task automatic test_reset_mid();
    int fire_edge;
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    empty_v = 3'b000; fire_edge = -1;
    for (int e = 1; e <= TIMEOUT + 20; e++) begin
      rst = (e == 15);
      tick();
      if (soft_reset_1 && fire_edge < 0) fire_edge = e;
      tests++; if (sr !== exp_sr) begin fails++; $display("FAIL rstmid edge=%0d got=%b exp=%b", e, sr, exp_sr); end
    end
    tests++; if (fire_edge !== (SR_EN ? 15 + TIMEOUT : -1)) begin
      fails++; $display("FAIL rstmid_fire got=%0d exp=%0d", fire_edge, SR_EN ? 15 + TIMEOUT : -1); end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 1500; n++) begin
      rst = 1'($urandom_range(0, 299) == 0);
      detect_addr = 1'($urandom_range(0, 7) == 0); data_in = 2'($urandom);
      write_enb_reg = 1'($urandom); full_v = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        empty_v[i] = ($urandom_range(0, 19) == 0);
        rd_v[i]    = ($urandom_range(0, 34) == 0);
      end
      #1;
      tests++; if (write_enb !== exp_we()) begin fails++; $display("FAIL mix_we n=%0d got=%b exp=%b", n, write_enb, exp_we()); end
      tests++; if (fifo_full !== exp_ff()) begin fails++; $display("FAIL mix_ff n=%0d got=%b exp=%b", n, fifo_full, exp_ff()); end
      tick();
      tests++; if (sr !== exp_sr) begin fails++; $display("FAIL mix_sr n=%0d got=%b exp=%b", n, sr, exp_sr); end
    end
  endtask

  initial begin
    m_addr = 3; exp_sr = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    idle_inputs();
    #2;
    test_reset();
    test_decode();
    test_timeout_port2();
    test_read_late();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
